// File: rtl/if_fetch_queue_pkg.sv
// ============================================================================
// if_fetch_queue_pkg : shared defaults and entry layout for the fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

package if_fetch_queue_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_INST_WIDTH = 32;
    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_RESET_PC = '0;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_INST_WIDTH-1:0] inst;
        logic                      misaligned;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_queue_fifo.sv
// ============================================================================
// fq_fifo : synchronous FIFO with flush, occupancy count and fall-through head
// Rev 1.0
// ============================================================================
`default_nettype none

module fq_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ============================================================================
// if_fetch_queue : pipelined instruction fetch with FQ_DEPTH-entry queue to ID
// Optional: define IF_MISALIGN_EN for misaligned-redirect flagging and halt.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    INST_WIDTH = DEF_INST_WIDTH,
    parameter int                    FQ_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
`ifdef IF_MISALIGN_EN
    output logic                  fetch_misalign,
`endif
    output logic [INST_WIDTH-1:0] inst_out
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
`ifdef IF_MISALIGN_EN
    localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH + 1;
`else
    localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;
`endif

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  halted;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count;
    logic [ENTRY_W-1:0]    push_data;
    logic [ENTRY_W-1:0]    head_data;

    // Queue slots are reserved at issue time, so a response always has room
    assign issue    = !rst && !branch_taken && !halted
                      && ((count + CW'(inflight)) < CW'(FQ_DEPTH));
    assign push     = inflight && !branch_taken;
    assign pop      = inst_valid && inst_ready;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

`ifdef IF_MISALIGN_EN
    logic inflight_mis;

    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            halted       <= 1'b0;
            inflight_mis <= 1'b0;
        end else begin
            inflight_mis <= issue && (fetch_pc[1:0] != 2'b00);
            if (issue && (fetch_pc[1:0] != 2'b00))
                halted <= 1'b1;
        end
    end

    assign push_data      = {inflight_pc, imem_rdata, inflight_mis};
    assign pc_out         = inst_valid ? head_data[ENTRY_W-1 -: ADDR_WIDTH] : '0;
    assign inst_out       = inst_valid ? head_data[INST_WIDTH:1] : '0;
    assign fetch_misalign = inst_valid && head_data[0];
`else
    assign halted    = 1'b0;
    assign push_data = {inflight_pc, imem_rdata};
    assign pc_out    = inst_valid ? head_data[ENTRY_W-1 -: ADDR_WIDTH] : '0;
    assign inst_out  = inst_valid ? head_data[INST_WIDTH-1:0] : '0;
`endif

    assign inst_valid = (count != '0) && !branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (branch_taken) begin
            fetch_pc <= branch_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
        end
    end

    fq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_taken),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

endmodule

`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-slot IF stage.
- Owns the fetch PC, issues pipelined requests to a 1-cycle-latency synchronous instruction memory, and buffers returned instructions with their PCs in an FQ_DEPTH-entry FIFO.
- Presents instructions to ID through a valid/ready handshake.
- Accepts branch redirects from EX, flushing all buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, fetch/PC address width.
- INST_WIDTH, 32, instruction width.
- FQ_DEPTH, 4, queue entries; power of two, >=2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- branch_taken  in  1  redirect request from EX.
- branch_addr  in  ADDR_WIDTH  redirect target.
- imem_req  out  1  memory read request this cycle.
- imem_addr  out  ADDR_WIDTH  read address.
- imem_rdata  in  INST_WIDTH  read data, valid the cycle after imem_req.
- inst_valid  out  1  head entry available to ID.
- inst_ready  in  1  ID accepts head; deasserted while ID is stalled.
- pc_out  out  ADDR_WIDTH  PC of head entry.
- inst_out  out  INST_WIDTH  instruction of head entry.

Behaviour:
- **Reset** (rst sampled high at a clk edge):
  - fetch_pc=RESET_PC; count=0; inflight=0; read/write pointers=0.
  - inst_valid=0, imem_req=0, pc_out=0, inst_out=0.
  - rst has priority over every other input, including a fetch in progress (the response is dropped).
- **Issue**:
  - imem_req = !rst && !branch_taken && (count + inflight < FQ_DEPTH).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4, modulo 2^ADDR_WIDTH (wraps silently); inflight<=1; inflight_pc<=fetch_pc.
  - If no issue this cycle: inflight<=0.
- **Response**: in the cycle after an issue, if inflight=1 and no branch_taken, {inflight_pc, imem_rdata} is written at the write pointer at the clk edge. The reservation rule guarantees space, including the full-with-pop case.
- **Output**:
  - inst_valid = (count!=0) && !branch_taken.
  - pc_out/inst_out = head entry when inst_valid, else 0.
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FQ_DEPTH.
- **Redirect** (branch_taken high in cycle N):
  - Handshake suppressed; no issue.
  - At the edge: count=0, pointers=0, inflight=0 (the pending response is discarded), fetch_pc=branch_addr.
  - Cycle N+1: imem_req with imem_addr=branch_addr.
  - Cycle N+3: inst_valid with pc_out=branch_addr.
  - branch_taken on consecutive cycles: the last target wins.
- **Latency**: reset release to first inst_valid is 2 cycles (issue, response, visible).
- **Throughput**: with inst_ready held high, sustained 1 inst/cycle.
- **Stall**: with inst_ready low, the queue fills to FQ_DEPTH, then imem_req drops. Exactly FQ_DEPTH entries, no loss or duplication.

Optional Feature:
- Macro: IF_MISALIGN_EN.
- **Defined**:
  - Adds output port fetch_misalign (1 bit) and stores a misaligned bit with each entry.
  - branch_addr[1:0]!=0 at redirect marks the first fetched entry misaligned; fetch_misalign is presented with that head entry.
  - Issue then halts (imem_req=0) until the next redirect or reset.
  - The reset value of fetch_misalign is 0.
- **Undefined**: no port, no stored bit; branch_addr[1:0] are used unchecked.

Decomposition:
- Shared package holds:
  - ADDR_WIDTH/INST_WIDTH defaults.
  - RESET_PC.
  - PC_STEP=4.
  - A fq_entry_t struct {pc, inst, misaligned}.
- One natural sub-module: fq_fifo (parametrised sync FIFO with flush input, count output, and combinational head read).
- PC/issue/redirect logic stays in the top module.

Test Plan:
- Reset, inst_ready=1, imem returns addr+0x100 as data -> imem_addr 0,4,8,… from the cycle after reset release; pc_out=0 first seen 2 cycles after release, then one inst per cycle, inst_out=pc+0x100.
- inst_ready=0 for 10 cycles after reset -> exactly 4 imem_req pulses (addr 0..0xC), count=4, no further requests; release -> pops 0,4,8,0xC in order, then fetch resumes at 0x10.
- branch_taken=1, branch_addr=0x200 while queue holds 3 entries and one is in flight -> inst_valid=0 that cycle; next cycle imem_addr=0x200; 2 cycles later pc_out=0x200; no stale PC ever emitted.
- branch_taken on two consecutive cycles (0x300 then 0x400) -> only 0x400 fetched; first visible pc_out=0x400.
- rst asserted mid-stream with full queue -> the next cycle has inst_valid=0 and imem_req=0; fetch restarts at RESET_PC.
- IF_MISALIGN_EN: redirect to 0x202 -> one entry with fetch_misalign=1 and pc_out=0x202, imem_req stays 0 until a redirect to 0x300 restarts fetch normally.
